// File: rtl/rob_commit_scheduler.sv
// In-order commit sequencer and ROB-id allocator for the register file.
// Ids run 1..ROB_SIZE; id 0 means "no dependency" and is never handed out.
// Optional macro WB_COMMIT_BYPASS_EN: a writeback hitting the head commits on the same edge.
module rob_commit_scheduler #(
  parameter int unsigned ROB_SIZE = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _issue_valid,
  input  logic [4:0]  _issue_rd,
  output logic        _issue_ready,
  output logic [4:0]  _issue_rob_id,
  input  logic        _wb_valid,
  input  logic [4:0]  _wb_rob_id,
  input  logic [31:0] _wb_value,
  output logic        _rob_launch_ready,
  output logic [4:0]  _rob_launch_rob_id,
  output logic [4:0]  _rob_launch_register_id,
  output logic        _rob_commit_ready,
  output logic [4:0]  _rob_commit_rob_id,
  output logic [4:0]  _rob_commit_register_id,
  output logic [31:0] _rob_commit_value,
  output logic [5:0]  _count,
  output logic        _empty
);

  localparam logic [4:0] LastId   = 5'(ROB_SIZE);
  localparam logic [5:0] Capacity = 6'(ROB_SIZE);

  // Indexed directly by the 5-bit id; slot 0 and slots above ROB_SIZE are never written.
  logic [31:0] valid_q;
  logic [31:0] done_q;
  logic [4:0]  rd_q    [32];
  logic [31:0] value_q [32];

  logic [4:0]  head_q, tail_q;
  logic [5:0]  count_q, count_d;
  logic        commit_ready_q;
  logic [4:0]  commit_rob_id_q, commit_rd_q;
  logic [31:0] commit_value_q;

  logic        launch;
  logic        wb_hit;
  logic        commit_fire;
  logic [31:0] commit_val;

  function automatic logic [4:0] next_id(input logic [4:0] id);
    return (id == LastId) ? 5'd1 : id + 5'd1;
  endfunction

  // Issue/writeback/commit decisions and occupancy next state.
  always_comb begin
    _issue_ready = (count_q < Capacity);
    launch       = _issue_valid & _issue_ready & rdy_in & ~_clear;
    wb_hit       = _wb_valid && (_wb_rob_id != 5'd0) && (_wb_rob_id <= LastId) &&
                   valid_q[_wb_rob_id] && !done_q[_wb_rob_id];
`ifdef WB_COMMIT_BYPASS_EN
    commit_fire  = valid_q[head_q] &&
                   (done_q[head_q] || (wb_hit && (_wb_rob_id == head_q)));
    commit_val   = done_q[head_q] ? value_q[head_q] : _wb_value;
`else
    commit_fire  = valid_q[head_q] && done_q[head_q];
    commit_val   = value_q[head_q];
`endif
    count_d = count_q;
    unique case ({launch, commit_fire})
      2'b10:   count_d = count_q + 6'd1;
      2'b01:   count_d = count_q - 6'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, occupancy, valid/done flags and the registered commit port.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q          <= 5'd1;
      tail_q          <= 5'd1;
      count_q         <= 6'd0;
      valid_q         <= '0;
      done_q          <= '0;
      commit_ready_q  <= 1'b0;
      commit_rob_id_q <= 5'd0;
      commit_rd_q     <= 5'd0;
      commit_value_q  <= 32'd0;
    end else if (rdy_in) begin
      if (_clear) begin
        head_q         <= 5'd1;
        tail_q         <= 5'd1;
        count_q        <= 6'd0;
        valid_q        <= '0;
        done_q         <= '0;
        commit_ready_q <= 1'b0;
      end else begin
        if (wb_hit) done_q[_wb_rob_id] <= 1'b1;
        // Issue and commit never touch the same slot: that would need a full ROB.
        if (launch) begin
          valid_q[tail_q] <= 1'b1;
          done_q[tail_q]  <= 1'b0;
          tail_q          <= next_id(tail_q);
        end
        if (commit_fire) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= next_id(head_q);
          commit_rob_id_q <= head_q;
          commit_rd_q     <= rd_q[head_q];
          commit_value_q  <= commit_val;
        end
        commit_ready_q <= commit_fire;
        count_q        <= count_d;
      end
    end
  end

  // Entry payload storage; needs no reset since valid/done qualify it.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !_clear) begin
      if (launch) rd_q[tail_q] <= _issue_rd;
      if (wb_hit) value_q[_wb_rob_id] <= _wb_value;
    end
  end

  assign _issue_rob_id           = tail_q;
  assign _rob_launch_ready       = launch;
  assign _rob_launch_rob_id      = tail_q;
  assign _rob_launch_register_id = _issue_rd;
  assign _rob_commit_ready       = commit_ready_q;
  assign _rob_commit_rob_id      = commit_rob_id_q;
  assign _rob_commit_register_id = commit_rd_q;
  assign _rob_commit_value       = commit_value_q;
  assign _count                  = count_q;
  assign _empty                  = (count_q == 6'd0);

endmodule

// File: doc/rob_commit_scheduler.md
Name: rob_commit_scheduler

Overview:
In-order commit sequencer and ROB-id allocator for the register file.
- Hands out 5-bit ROB ids to issuing instructions and drives the register file launch port, so the RF records the rename dependency.
- Collects execution writebacks and drives the register file commit port strictly in program order, one entry per cycle.
- Sits between decode/issue, the execution units' CDB and the register file.

Parameters:
ROB_SIZE, 16, number of in-flight entries; legal range 2..31; ids used are 1..ROB_SIZE (id 0 reserved for "no dependency").

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; when low all state holds
_clear  input  1  pipeline flush
_issue_valid  input  1  issue request this cycle
_issue_rd  input  5  destination register of issuing instruction (0 = none)
_issue_ready  output  1  entry available (combinational, count<ROB_SIZE)
_issue_rob_id  output  5  id assigned to the issue this cycle (= tail pointer)
_wb_valid  input  1  execution result valid
_wb_rob_id  input  5  id of result
_wb_value  input  32  result value
_rob_launch_ready  output  1  combinational: _issue_valid & _issue_ready & rdy_in & !_clear
_rob_launch_rob_id  output  5  = _issue_rob_id
_rob_launch_register_id  output  5  = _issue_rd
_rob_commit_ready  output  1  registered commit strobe
_rob_commit_rob_id  output  5  registered committing id
_rob_commit_register_id  output  5  registered destination register
_rob_commit_value  output  32  registered committed value
_count  output  6  occupied entries
_empty  output  1  count==0

Behaviour:
- Per-entry state: valid, done, rd[4:0], value[31:0]. Head and tail pointers range 1..ROB_SIZE; increment wraps from ROB_SIZE to 1, never 0.
- Reset (sync, rst_in=1 at edge): head=tail=1, count=0, all valid/done=0.
  - All registered outputs reset to 0.
  - Reset takes priority over _clear and rdy_in.
- rdy_in=0: no state or registered output changes. Launch output is forced 0.
- Issue accept at edge when launch condition holds:
  - entry[tail] gets valid=1, done=0, rd=_issue_rd; tail advances.
  - _issue_ready is computed from the pre-edge count. A same-edge commit never frees space for a same-edge issue when full.
- Writeback at edge: if _wb_valid and entry[_wb_rob_id] is valid and not done, set done=1 and value=_wb_value.
  - Ignored if the id is 0, >ROB_SIZE, invalid or already done.
- Commit decision at each edge:
  - If entry[head] is valid and done (as held before the edge), assert _rob_commit_ready=1 with the id, rd and value, clear entry valid, and advance head.
  - Otherwise _rob_commit_ready=0.
  - Latency: writeback sampled at edge E gives commit outputs valid after edge E+1.
  - Entries with rd=0 still commit (one cycle; the RF drops the write).
- Simultaneous issue and commit in one edge: count unchanged. Issue-only: +1. Commit-only: -1.
- Issue into the slot freed by the same-edge commit cannot occur, because full blocks issue.
- _clear=1 (rdy_in=1):
  - All entries invalidated, head=tail=1, count=0, _rob_commit_ready<=0.
  - Issue and writeback in that cycle are discarded.
  - A commit pending on that edge is dropped.
- Wrap-around: after id ROB_SIZE is assigned, the next issue gets id 1.

Optional Feature:
WB_COMMIT_BYPASS_EN
- Defined: if _wb_valid targets the current head, and the head entry is valid and not done, commit in the same edge using _wb_value. Commit outputs are valid after edge E (latency 0 extra cycles). The entry's done bit is not needed.
- Undefined: 1-cycle latency as above.

Test Plan:
- Reset then issue rd=5,6,7 on consecutive cycles → ids 1,2,3; launch port shows (1,5),(2,6),(3,7); _count=3.
- Writebacks id2=0x22 then id1=0x11 → commits in order: id1/rd5/0x11 the cycle after the id1 writeback, then id2/rd6/0x22 the next cycle; nothing for id3 until its writeback.
- Fill ROB_SIZE=16 entries → _issue_ready=0 and further _issue_valid is ignored (no launch strobe). Writeback and commit of id1 → _issue_ready returns, and the next issue gets id 1 (wrap).
- Issue rd=0 then writeback 0xDEAD → commit strobe with register_id=0, value 0xDEAD; _count decrements.
- 4 entries in flight, id1 done, assert _clear → no commit next cycle, _count=0, next issue gets id 1. Stale writeback to id3 after the flush is ignored.
- rdy_in=0 for 3 cycles with a done head → commit outputs hold and no commit occurs; commit happens on the first edge with rdy_in=1. With WB_COMMIT_BYPASS_EN, a writeback to the head commits on the same edge.
